// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write ports, two registered read
// ports with write-to-read bypass, and a per-register busy scoreboard.
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2,
    output logic             busy1,
    output logic             busy2,
    output logic             rvalid,
    input  logic             we0,
    input  logic [AW-1:0]    waddr0,
    input  logic [WIDTH-1:0] wdata0,
    input  logic             we1,
    input  logic [AW-1:0]    waddr1,
    input  logic [WIDTH-1:0] wdata1,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr
);

    localparam bit HAS_ZERO = (ZERO_REG != 0);

    logic [WIDTH-1:0] regs     [DEPTH];
    logic [WIDTH-1:0] regs_nxt [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_nxt;

    // Post-edge state of every register; reads index this, which gives bypass for free.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_nxt[i] = regs[i];
            busy_nxt[i] = busy_q[i];
            if (HAS_ZERO && i == 0) begin
                regs_nxt[i] = '0;
                busy_nxt[i] = 1'b0;
            end else begin
                if (we1 && waddr1 == AW'(i)) begin
                    regs_nxt[i] = wdata1;
                end else if (we0 && waddr0 == AW'(i)) begin
                    regs_nxt[i] = wdata0;
                end
                // A new reservation beats the completing write of the old producer.
                if (rsv_en && rsv_addr == AW'(i)) begin
                    busy_nxt[i] = 1'b1;
                end else if ((we1 && waddr1 == AW'(i)) || (we0 && waddr0 == AW'(i))) begin
                    busy_nxt[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs   <= '{default: '0};
            busy_q <= '0;
            rdata1 <= '0;
            rdata2 <= '0;
            busy1  <= 1'b0;
            busy2  <= 1'b0;
            rvalid <= 1'b0;
        end else begin
            regs   <= regs_nxt;
            busy_q <= busy_nxt;
            rvalid <= rd_en;
            if (rd_en) begin
                rdata1 <= regs_nxt[raddr1];
                rdata2 <= regs_nxt[raddr2];
                busy1  <= busy_nxt[raddr1];
                busy2  <= busy_nxt[raddr2];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: reset, write priority, bypass,
// zero register, scoreboard, reserve/write collision and output hold.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        busy1, busy2, rvalid;
    logic        we0, we1;
    logic [4:0]  waddr0, waddr1;
    logic [31:0] wdata0, wdata1;
    logic        rsv_en;
    logic [4:0]  rsv_addr;

    int testsRun  = 0;
    int failCount = 0;

    regfile_mp #(.WIDTH(32), .DEPTH(32), .AW(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2), .busy1(busy1), .busy2(busy2), .rvalid(rvalid),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr)
    );

    always #5 clk = ~clk;

    // One clock edge, then drop all strobes so each step only sets what it needs.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        rd_en  = 1'b0;
        we0    = 1'b0;
        we1    = 1'b0;
        rsv_en = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkFlag(input string tag, input logic obs, input logic exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        rd_en = 1'b0; raddr1 = '0; raddr2 = '0;
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        rsv_en = 1'b0; rsv_addr = '0;
        applyStimulus();
        applyStimulus();
        checkOutput("reset_rdata1", rdata1, 32'h0);
        checkOutput("reset_rdata2", rdata2, 32'h0);
        checkFlag("reset_rvalid", rvalid, 1'b0);
        checkFlag("reset_busy1", busy1, 1'b0);

        // Preload reg5 and reserve it, then reset with a write to reg6 pending
        rst = 1'b0;
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        rsv_en = 1'b1; rsv_addr = 5'd5;
        applyStimulus();
        rst = 1'b1;
        we0 = 1'b1; waddr0 = 5'd6; wdata0 = 32'h11;
        rd_en = 1'b1; raddr1 = 5'd5; raddr2 = 5'd6;
        applyStimulus();
        checkFlag("rvalid_during_reset", rvalid, 1'b0);
        rst = 1'b0;
        applyStimulus();
        checkFlag("rvalid_after_reset", rvalid, 1'b0);
        rd_en = 1'b1; raddr1 = 5'd5; raddr2 = 5'd6;
        applyStimulus();
        checkOutput("reset_reg5", rdata1, 32'h0);
        checkOutput("reset_reg6_write_dropped", rdata2, 32'h0);
        checkFlag("reset_busy5", busy1, 1'b0);
        checkFlag("reset_busy6", busy2, 1'b0);
        checkFlag("reset_read_rvalid", rvalid, 1'b1);

        // Same-address write priority with bypass
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'hAAAA0000;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h5555FFFF;
        rd_en = 1'b1; raddr1 = 5'd7;
        applyStimulus();
        checkOutput("prio_bypass", rdata1, 32'h5555FFFF);
        checkFlag("prio_rvalid", rvalid, 1'b1);
        rd_en = 1'b1; raddr1 = 5'd7;
        applyStimulus();
        checkOutput("prio_stored", rdata1, 32'h5555FFFF);

        // Port 0 alone bypasses too, and two different addresses both land
        we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'h0000000A;
        we1 = 1'b1; waddr1 = 5'd11; wdata1 = 32'h0000000B;
        rd_en = 1'b1; raddr1 = 5'd10; raddr2 = 5'd11;
        applyStimulus();
        checkOutput("dual_bypass_p0", rdata1, 32'h0000000A);
        checkOutput("dual_bypass_p1", rdata2, 32'h0000000B);
        rd_en = 1'b1; raddr1 = 5'd11; raddr2 = 5'd10;
        applyStimulus();
        checkOutput("dual_stored_11", rdata1, 32'h0000000B);
        checkOutput("dual_stored_10", rdata2, 32'h0000000A);

        // Zero register ignores writes and reserves, even under bypass
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        rd_en = 1'b1; raddr1 = 5'd0;
        applyStimulus();
        checkOutput("zero_bypass", rdata1, 32'h0);
        checkFlag("zero_busy_bypass", busy1, 1'b0);
        rd_en = 1'b1; raddr1 = 5'd0; raddr2 = 5'd0;
        applyStimulus();
        checkOutput("zero_stored", rdata1, 32'h0);
        checkFlag("zero_busy_stored", busy2, 1'b0);

        // Scoreboard: reserve, re-reserve, then a write clears busy
        rsv_en = 1'b1; rsv_addr = 5'd3;
        applyStimulus();
        rsv_en = 1'b1; rsv_addr = 5'd3;
        rd_en = 1'b1; raddr1 = 5'd3;
        applyStimulus();
        checkFlag("sb_reserved", busy1, 1'b1);
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h1234;
        rd_en = 1'b1; raddr1 = 5'd3;
        applyStimulus();
        checkOutput("sb_write_data", rdata1, 32'h1234);
        checkFlag("sb_write_clears", busy1, 1'b0);

        // Reserve and write on the same register in one cycle
        rsv_en = 1'b1; rsv_addr = 5'd9;
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h42;
        rd_en = 1'b1; raddr2 = 5'd9;
        applyStimulus();
        checkOutput("collide_bypass_data", rdata2, 32'h42);
        checkFlag("collide_bypass_busy", busy2, 1'b1);
        rd_en = 1'b1; raddr1 = 5'd9;
        applyStimulus();
        checkOutput("collide_data", rdata1, 32'h42);
        checkFlag("collide_busy", busy1, 1'b1);

        // Outputs hold while rd_en is low
        we0 = 1'b1; waddr0 = 5'd2; wdata0 = 32'h77;
        applyStimulus();
        rd_en = 1'b1; raddr1 = 5'd2;
        applyStimulus();
        checkOutput("hold_first_read", rdata1, 32'h77);
        we0 = 1'b1; waddr0 = 5'd2; wdata0 = 32'h88;
        applyStimulus();
        checkOutput("hold_data", rdata1, 32'h77);
        checkFlag("hold_rvalid", rvalid, 1'b0);
        applyStimulus();
        checkOutput("hold_data_idle", rdata1, 32'h77);
        rd_en = 1'b1; raddr1 = 5'd2;
        applyStimulus();
        checkOutput("hold_new_read", rdata1, 32'h88);
        checkFlag("hold_new_rvalid", rvalid, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the microprocessor datapath; successor to the single-write, combinational-read register file.
- Two write ports with fixed priority, two read ports with a registered one-cycle-latency output and write-to-read bypass, optional hardwired-zero register 0.
- Per-register busy scoreboard used by the issue stage to stall on pending results.
- Sits between decode/issue (reads, reserves) and writeback (writes).

Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 32, number of registers; power of two, at least 2.
- AW, 5, address width; must equal log2(DEPTH).
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes and reserves.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- rd_en  in  1  read request; samples raddr1/raddr2.
- raddr1  in  AW  read port 1 address.
- raddr2  in  AW  read port 2 address.
- rdata1  out  WIDTH  read port 1 data (registered).
- rdata2  out  WIDTH  read port 2 data (registered).
- busy1  out  1  busy bit of raddr1 (registered with rdata1).
- busy2  out  1  busy bit of raddr2 (registered with rdata2).
- rvalid  out  1  one-cycle pulse, rdata/busy updated this cycle.
- we0  in  1  write enable, port 0.
- waddr0  in  AW  write address, port 0.
- wdata0  in  WIDTH  write data, port 0.
- we1  in  1  write enable, port 1 (higher priority).
- waddr1  in  AW  write address, port 1.
- wdata1  in  WIDTH  write data, port 1.
- rsv_en  in  1  reserve request; marks rsv_addr busy.
- rsv_addr  in  AW  register to reserve.

Behaviour:
- Reset: rst is sampled at the rising edge and has priority over all other inputs. It clears every register, every busy bit, rdata1/2, busy1/2 and rvalid to 0. A read, write or reserve presented in the reset cycle is discarded.
- Write: at the edge, reg[waddrN] <= wdataN when weN=1.
  - Same address on both ports: port 1 value is stored, port 0 is dropped.
  - Different addresses: both are stored.
- Read latency is 1 cycle. When rd_en=1 at edge T, rdata1/2, busy1/2 are updated at T and rvalid=1 during cycle T..T+1.
  - When rd_en=0, rvalid=0 and rdata/busy hold their previous values.
- Bypass: the read returns the post-edge contents. If a write in the same cycle targets raddrN, rdataN is the write data, with port 1 winning over port 0. Reads never see stale data.
- Zero register (ZERO_REG=1):
  - Writes to address 0 are ignored.
  - Reads of address 0 return 0, including under bypass.
  - rsv_en to address 0 is ignored, and busy for address 0 is always 0.
- Scoreboard: busy[i] is set when rsv_en=1 and rsv_addr=i, and cleared when either write port writes i.
  - Reserve and write to the same address in one cycle: busy ends set (the new producer wins); the data is still written.
  - busyN output is the post-edge busy state of raddrN, consistent with bypass.
- Reserving an already-busy register keeps it busy (no counting). A write to a non-busy register is legal and leaves busy=0.
- Addresses are always in range; no out-of-range handling is required when DEPTH=2^AW.
- Outputs are fully registered, with no combinational path from inputs to outputs.

Test Plan:
- Reset: preload reg5=0xDEADBEEF, then assert rst while we0=1 writes waddr0=6, wdata0=0x11. Read 5 and 6 next → rdata1=0, rdata2=0, busy=0; rvalid=0 during and one cycle after reset.
- Priority and bypass: in one cycle, we0 (addr 7, 0xAAAA0000), we1 (addr 7, 0x5555FFFF), rd_en=1, raddr1=7 → next cycle rdata1=0x5555FFFF, rvalid=1. A later read of 7 also returns 0x5555FFFF.
- Zero register: we1 writes addr 0 with 0xFFFFFFFF and rsv_en targets addr 0, with a same-cycle read of raddr1=0 → rdata1=0, busy1=0. A subsequent read still gives 0.
- Scoreboard: rsv_en addr 3 → read 3 gives busy1=1. Then we0 writes addr 3 (0x1234) with a same-cycle read → rdata1=0x1234, busy1=0.
- Reserve/write collision: rsv_en addr 9 and we0 addr 9 (0x42) in the same cycle → read gives rdata=0x42, busy=1.
- Hold: read 2 (0x77), then rd_en=0 while writing reg2=0x88 → rdata1 stays 0x77 and rvalid=0 until the next rd_en.
